// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: load types and FSM states.
package mem_pkg;

    localparam int unsigned DATA_W = 32;

    // Load-type codes carried down the pipe in E_LoadType
    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LBU = 3'd1,
        LT_LH  = 3'd2,
        LT_LHU = 3'd3,
        LT_LW  = 3'd4
    } load_type_e;

    // Data-SRAM handshake FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Byte/half selection and sign/zero extension of a returned load word.
module load_extend
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        load_type_i,
    output logic [DATA_W-1:0] value_o
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    // Pick the addressed byte/half and extend it per load type; unknown codes behave as LW
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        value_o = rdata_i;
        case (load_type_i)
            LT_LB:   value_o = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  value_o = {24'd0, byte_v};
            LT_LH:   value_o = {{16{half_v[15]}}, half_v};
            LT_LHU:  value_o = {16'd0, half_v};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// E->M pipeline stage: drives the data-SRAM request channel, stalls upstream
// until the response arrives, and drains orphan responses after a flush.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              exp_flush,
    input  logic [31:0]       E_Data,
    input  logic [31:0]       E_WriteMemData,
    input  logic [3:0]        E_MemWriteEnable,
    input  logic              E_MemRead,
    input  logic [2:0]        E_LoadType,
    input  logic [3:0]        E_T,
    input  logic              E_WriteRegEnable,
    input  logic [4:0]        E_RegId,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic [3:0]        M_T,
    output logic              M_WriteRegEnable,
    output logic [4:0]        M_RegId,
    output logic [31:0]       M_Data,
    output logic              dm_stall
);

    mem_state_e  state_q, state_d;
    logic        drain_q, drain_d;
    logic        mem_op, stall;
    logic [31:0] ext_data;

    logic [3:0]  m_t_q, m_t_d;
    logic        m_we_q, m_we_d;
    logic [4:0]  m_rid_q, m_rid_d;
    logic [31:0] m_data_q, m_data_d;

    assign mem_op = E_MemRead | (|E_MemWriteEnable);

    load_extend u_load_extend (
        .rdata_i     (data_sram_rdata),
        .offset_i    (E_Data[1:0]),
        .load_type_i (E_LoadType),
        .value_o     (ext_data)
    );

    // Request fields come straight from E, which the stall keeps frozen until addr_ok
    assign data_sram_req   = Clr_n && (state_q == ST_REQ);
    assign data_sram_wr    = |E_MemWriteEnable;
    assign data_sram_wstrb = E_MemWriteEnable;
    assign data_sram_addr  = ADDR_W'({E_Data[31:2], 2'b00});
    assign data_sram_wdata = E_WriteMemData;
    assign dm_stall        = stall;

    // Next state, drain tracking and stall; a flushed instruction never stalls
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        stall   = 1'b0;
        if (drain_q && data_sram_data_ok) drain_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !exp_flush) begin
                    stall = 1'b1;
                    // The orphan response arriving this cycle frees the channel
                    if (!drain_q || data_sram_data_ok) state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = mem_op && !exp_flush && !(data_sram_addr_ok && data_sram_data_ok);
                if (data_sram_addr_ok && !data_sram_data_ok) begin
                    // Accepted but flushed: its response must be swallowed later
                    state_d = exp_flush ? ST_IDLE : ST_WAIT;
                    drain_d = exp_flush;
                end else if (data_sram_addr_ok || exp_flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall = mem_op && !exp_flush && !data_sram_data_ok;
                if (data_sram_data_ok) begin
                    state_d = ST_IDLE;
                end else if (exp_flush) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // M-stage next values: bubble on flush, hold on stall, else take E
    always_comb begin
        m_t_d    = m_t_q;
        m_we_d   = m_we_q;
        m_rid_d  = m_rid_q;
        m_data_d = m_data_q;
        if (exp_flush) begin
            m_t_d    = 4'd0;
            m_we_d   = 1'b0;
            m_rid_d  = 5'd0;
            m_data_d = 32'd0;
        end else if (!stall) begin
            m_t_d    = (E_T == 4'd0) ? 4'd0 : E_T - 4'd1;
            m_we_d   = E_WriteRegEnable;
            m_rid_d  = E_RegId;
            m_data_d = E_MemRead ? ext_data : E_Data;
        end
    end

    // State and M registers with synchronous active-low clear
    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state_q  <= ST_IDLE;
            drain_q  <= 1'b0;
            m_t_q    <= 4'd0;
            m_we_q   <= 1'b0;
            m_rid_q  <= 5'd0;
            m_data_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            m_t_q    <= m_t_d;
            m_we_q   <= m_we_d;
            m_rid_q  <= m_rid_d;
            m_data_q <= m_data_d;
        end
    end

    assign M_T              = m_t_q;
    assign M_WriteRegEnable = m_we_q;
    assign M_RegId          = m_rid_q;
    assign M_Data           = m_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with an expected-result queue for M outputs.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Clr_n, exp_flush;
    logic [31:0] E_Data, E_WriteMemData;
    logic [3:0]  E_MemWriteEnable;
    logic        E_MemRead;
    logic [2:0]  E_LoadType;
    logic [3:0]  E_T;
    logic        E_WriteRegEnable;
    logic [4:0]  E_RegId;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  M_T;
    logic        M_WriteRegEnable;
    logic [4:0]  M_RegId;
    logic [31:0] M_Data;
    logic        dm_stall;

    typedef struct {
        logic [3:0]  t;
        logic        we;
        logic [4:0]  rid;
        logic [31:0] data;
    } m_exp_t;

    m_exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage #(.ADDR_W(32)) dut (
        .Clk(Clk), .Clr_n(Clr_n), .exp_flush(exp_flush),
        .E_Data(E_Data), .E_WriteMemData(E_WriteMemData),
        .E_MemWriteEnable(E_MemWriteEnable), .E_MemRead(E_MemRead),
        .E_LoadType(E_LoadType), .E_T(E_T), .E_WriteRegEnable(E_WriteRegEnable),
        .E_RegId(E_RegId),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .M_T(M_T), .M_WriteRegEnable(M_WriteRegEnable), .M_RegId(M_RegId),
        .M_Data(M_Data), .dm_stall(dm_stall)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_e(input logic [3:0] t, input logic we, input logic [4:0] rid,
                         input logic [31:0] data, input logic rd, input logic [2:0] lt,
                         input logic [3:0] strb, input logic [31:0] wd);
        E_T = t; E_WriteRegEnable = we; E_RegId = rid; E_Data = data;
        E_MemRead = rd; E_LoadType = lt; E_MemWriteEnable = strb; E_WriteMemData = wd;
    endtask

    task automatic nop();
        set_e(4'd0, 1'b0, 5'd0, 32'd0, 1'b0, LT_LW, 4'd0, 32'd0);
    endtask

    // Expected M contents for an instruction leaving E with tag t
    task automatic push_exp(input logic [3:0] t, input logic we, input logic [4:0] rid,
                            input logic [31:0] d);
        m_exp_t e;
        e.t    = (t == 4'd0) ? 4'd0 : t - 4'd1;
        e.we   = we;
        e.rid  = rid;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        m_exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: scoreboard empty, observed M_Data %h", tag, M_Data);
        end else begin
            e = sb.pop_front();
            chk({tag, ".M_T"},  32'(M_T), 32'(e.t));
            chk({tag, ".M_WE"}, 32'(M_WriteRegEnable), 32'(e.we));
            chk({tag, ".M_Rd"}, 32'(M_RegId), 32'(e.rid));
            chk({tag, ".M_Data"}, M_Data, e.data);
        end
    endtask

    // Load with addr_ok in the REQ cycle, waitc empty WAIT cycles, then data_ok
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] lt,
                           input logic [4:0] rid, input logic [31:0] rd, input int waitc,
                           input logic [31:0] expd);
        int stalls = 0;
        set_e(4'd3, 1'b1, rid, addr, 1'b1, lt, 4'd0, 32'd0);
        push_exp(4'd3, 1'b1, rid, expd);
        #1;
        if (dm_stall) stalls++;
        chk({tag, ".req_idle"}, 32'(data_sram_req), 32'd0);
        tick();
        chk({tag, ".req"}, 32'(data_sram_req), 32'd1);
        chk({tag, ".addr"}, data_sram_addr, {addr[31:2], 2'b00});
        chk({tag, ".wr"}, 32'(data_sram_wr), 32'd0);
        data_sram_addr_ok = 1'b1;
        #1;
        if (dm_stall) stalls++;
        tick();
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            #1;
            if (dm_stall) stalls++;
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({tag, ".stall_dataok"}, 32'(dm_stall), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(2 + waitc));
        sb_check(tag);
        nop();
    endtask

    initial begin
        Clr_n = 1'b0; exp_flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        nop();
        tick(); tick();
        chk("rst.M_T", 32'(M_T), 32'd0);
        chk("rst.M_WE", 32'(M_WriteRegEnable), 32'd0);
        chk("rst.M_Rd", 32'(M_RegId), 32'd0);
        chk("rst.M_Data", M_Data, 32'd0);
        chk("rst.req", 32'(data_sram_req), 32'd0);
        chk("rst.stall", 32'(dm_stall), 32'd0);
        Clr_n = 1'b1;

        // ALU op: one-cycle latency, tag decremented, no stall
        set_e(4'd2, 1'b1, 5'd3, 32'd5, 1'b0, LT_LW, 4'd0, 32'd0);
        push_exp(4'd2, 1'b1, 5'd3, 32'd5);
        #1;
        chk("add.stall", 32'(dm_stall), 32'd0);
        chk("add.req", 32'(data_sram_req), 32'd0);
        tick();
        sb_check("add");
        nop();

        // Loads and extensions
        do_load("lw100", 32'h100, LT_LW, 5'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        do_load("lb103", 32'h103, LT_LB, 5'd6, 32'h80FF1234, 0, 32'hFFFFFF80);
        do_load("lbu103", 32'h103, LT_LBU, 5'd6, 32'h80FF1234, 0, 32'h00000080);
        do_load("lh102", 32'h102, LT_LH, 5'd6, 32'h80FF1234, 0, 32'hFFFF80FF);
        do_load("lhu102", 32'h102, LT_LHU, 5'd6, 32'h80FF1234, 2, 32'h000080FF);
        do_load("lb100", 32'h100, LT_LB, 5'd6, 32'h80FF1234, 0, 32'h00000034);

        // Store with addr_ok and data_ok together in the request cycle
        set_e(4'd0, 1'b0, 5'd0, 32'h200, 1'b0, LT_LW, 4'b0011, 32'h0000ABCD);
        push_exp(4'd0, 1'b0, 5'd0, 32'h200);
        #1;
        chk("sw.stall_idle", 32'(dm_stall), 32'd1);
        tick();
        chk("sw.req", 32'(data_sram_req), 32'd1);
        chk("sw.wr", 32'(data_sram_wr), 32'd1);
        chk("sw.wstrb", 32'(data_sram_wstrb), 32'b0011);
        chk("sw.wdata", data_sram_wdata, 32'h0000ABCD);
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
        #1;
        chk("sw.stall_req", 32'(dm_stall), 32'd0);
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        sb_check("sw");
        nop();
        #1;
        chk("sw.req_done", 32'(data_sram_req), 32'd0);
        tick();

        // Flush in WAIT, then a new load must wait for the orphan response
        set_e(4'd3, 1'b1, 5'd7, 32'h300, 1'b1, LT_LW, 4'd0, 32'd0);
        #1; tick();
        data_sram_addr_ok = 1'b1;
        #1; tick();
        data_sram_addr_ok = 1'b0;
        exp_flush = 1'b1;
        push_exp(4'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("fw.stall", 32'(dm_stall), 32'd0);
        tick();
        exp_flush = 1'b0;
        sb_check("fw.bubble");
        set_e(4'd2, 1'b1, 5'd8, 32'h304, 1'b1, LT_LW, 4'd0, 32'd0);
        push_exp(4'd2, 1'b1, 5'd8, 32'h12345678);
        #1;
        chk("drain.stall1", 32'(dm_stall), 32'd1);
        chk("drain.noreq1", 32'(data_sram_req), 32'd0);
        tick();
        #1;
        chk("drain.noreq2", 32'(data_sram_req), 32'd0);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
        #1;
        chk("drain.noreq3", 32'(data_sram_req), 32'd0);
        chk("drain.stall3", 32'(dm_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        chk("drain.orphan_dropped", M_Data, 32'd0);
        chk("drain.req_released", 32'(data_sram_req), 32'd1);
        chk("drain.addr", data_sram_addr, 32'h304);
        data_sram_addr_ok = 1'b1;
        #1; tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
        #1;
        chk("lw2.stall", 32'(dm_stall), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        sb_check("lw2");
        nop();

        // Flush in REQ before addr_ok: request dropped, bubble loaded
        set_e(4'd3, 1'b1, 5'd10, 32'h400, 1'b1, LT_LW, 4'd0, 32'd0);
        #1; tick();
        chk("fr.req", 32'(data_sram_req), 32'd1);
        exp_flush = 1'b1;
        push_exp(4'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("fr.stall", 32'(dm_stall), 32'd0);
        tick();
        exp_flush = 1'b0;
        nop();
        #1;
        chk("fr.req_dropped", 32'(data_sram_req), 32'd0);
        sb_check("fr.bubble");
        tick();

        // Reset during WAIT; a post-reset stray data_ok is ignored
        set_e(4'd3, 1'b1, 5'd4, 32'h77, 1'b0, LT_LW, 4'd0, 32'd0);
        push_exp(4'd3, 1'b1, 5'd4, 32'h77);
        #1; tick();
        sb_check("add2");
        set_e(4'd3, 1'b1, 5'd9, 32'h500, 1'b1, LT_LW, 4'd0, 32'd0);
        #1; tick();
        data_sram_addr_ok = 1'b1;
        #1; tick();
        data_sram_addr_ok = 1'b0;
        Clr_n = 1'b0;
        #1; tick();
        chk("rw.req", 32'(data_sram_req), 32'd0);
        chk("rw.M_T", 32'(M_T), 32'd0);
        chk("rw.M_WE", 32'(M_WriteRegEnable), 32'd0);
        chk("rw.M_Rd", 32'(M_RegId), 32'd0);
        chk("rw.M_Data", M_Data, 32'd0);
        Clr_n = 1'b1;
        set_e(4'd1, 1'b1, 5'd11, 32'h600, 1'b1, LT_LW, 4'd0, 32'd0);
        push_exp(4'd1, 1'b1, 5'd11, 32'hCAFEF00D);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555AAAA;
        #1;
        chk("rw.stall_idle", 32'(dm_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        chk("rw.req_after", 32'(data_sram_req), 32'd1);
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        #1;
        chk("rw.stall_req", 32'(dm_stall), 32'd0);
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        sb_check("rw.lw");
        nop();

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
